// File: rtl/unified_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bus bundle between the pipeline fetch/memory stages, the arbiter and the
// single-ported memory.
//   if_*   : fetch requester (req/addr in, rdata/ack out of the arbiter)
//   dm_*   : data requester (req/we/addr/wdata/be in, rdata/ack out)
//   mem_*  : memory port (req/we/addr/wdata/be out, rdata/ready in)
// Modports:
//   slave  : arbiter view
//   master : pipeline + memory view (stimulus side)
// ---------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic [DW-1:0]     if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic [DW/8-1:0]   dm_be;
    logic [DW-1:0]     dm_rdata;
    logic              dm_ack;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-ported memory between the fetch stage and the memory
// stage. One transaction is in flight at a time; data wins ties unless the
// fetch stage has already been passed over MAX_WAIT times in a row. A BUSY
// transaction that sees no mem_ready for TIMEOUT cycles is terminated with a
// zero-data ack and a sticky error flag.
// Ports:
//   clk1        : clock, rising edge
//   rst         : asynchronous active-low reset
//   bus         : fetch / data / memory bundle (slave modport)
//   stall_if    : fetch stage must hold (if_req & ~if_ack)
//   stall_mem   : memory stage must hold (dm_req & ~dm_ack)
//   err_timeout : sticky memory-timeout flag
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                    clk1,
    input  logic                    rst,
    unified_mem_arbiter_if.slave    bus,
    output logic                    stall_if,
    output logic                    stall_mem,
    output logic                    err_timeout
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [SW-1:0]   STARVE_ONE = SW'(1);
    // Count value seen during the TIMEOUT-th BUSY cycle (count starts at 0).
    localparam logic [TW-1:0]   BUSY_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   BUSY_ONE   = TW'(1);
    localparam logic [DW/8-1:0] BE_ALL     = {(DW/8){1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [SW-1:0] starve_cnt_r;
    logic [TW-1:0] busy_cnt_r;
    logic          busy_s;
    logic          timeout_s;
    logic          done_s;
    logic          grant_dm_s;
    logic          grant_if_s;

    // Grant decision, completion and timeout detection.
    always_comb begin
        busy_s     = (state_r == ST_BUSY_IF) || (state_r == ST_BUSY_DM);
        timeout_s  = busy_s && !bus.mem_ready && (busy_cnt_r == BUSY_LAST);
        done_s     = busy_s && (bus.mem_ready || timeout_s);
        // Data has priority unless the fetch stage has waited out its quota.
        grant_dm_s = (state_r == ST_IDLE) && bus.dm_req &&
                     !(bus.if_req && (starve_cnt_r == STARVE_MAX));
        grant_if_s = (state_r == ST_IDLE) && bus.if_req && !grant_dm_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_dm_s) begin
                    state_next_s = ST_BUSY_DM;
                end else if (grant_if_s) begin
                    state_next_s = ST_BUSY_IF;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                if (done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Requester-side outputs: acks and read data pass straight through from memory.
    always_comb begin
        bus.if_ack = (state_r == ST_BUSY_IF) && done_s;
        bus.dm_ack = (state_r == ST_BUSY_DM) && done_s;
        if (timeout_s) begin
            bus.if_rdata = {DW{1'b0}};
            bus.dm_rdata = {DW{1'b0}};
        end else begin
            bus.if_rdata = bus.mem_rdata;
            bus.dm_rdata = bus.mem_rdata;
        end
        stall_if  = bus.if_req & ~bus.if_ack;
        stall_mem = bus.dm_req & ~bus.dm_ack;
    end

    // State register.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory port registers: latched on grant, held for the whole transaction.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {AW{1'b0}};
            bus.mem_wdata <= {DW{1'b0}};
            bus.mem_be    <= {(DW/8){1'b0}};
        end else if (grant_dm_s) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            bus.mem_be    <= bus.dm_be;
        end else if (grant_if_s) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= {DW{1'b0}};
            bus.mem_be    <= BE_ALL;
        end else if (done_s) begin
            bus.mem_req   <= 1'b0;
        end
    end

    // Fetch starvation counter: data grants taken while fetch was waiting.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (grant_dm_s && bus.if_req) begin
            if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + STARVE_ONE;
            end
        end else if (grant_if_s || ((state_r == ST_IDLE) && !bus.if_req)) begin
            starve_cnt_r <= {SW{1'b0}};
        end
    end

    // BUSY cycle counter; stops at the limit since the transaction ends there.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            busy_cnt_r <= {TW{1'b0}};
        end else if (grant_dm_s || grant_if_s) begin
            busy_cnt_r <= {TW{1'b0}};
        end else if (busy_s && !bus.mem_ready && !timeout_s) begin
            busy_cnt_r <= busy_cnt_r + BUSY_ONE;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            err_timeout <= 1'b0;
        end else if (timeout_s) begin
            err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Directed scenarios with literal expectations followed by randomized
// traffic. A transaction-level model (owner, cycles spent, fetch pass-over
// count, grant log) predicts every output on each falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 16;

    logic clk1;
    logic rst;
    logic stall_if;
    logic stall_mem;
    logic err_timeout;

    unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    unified_mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .bus         (bus),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .err_timeout (err_timeout)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_cycle;   // 1-based BUSY cycle index of the current transaction
    int          m_passed;  // data grants taken in a row while fetch waited
    bit          m_err;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    int          grant_log[$];

    always @(negedge clk1) begin
        bit e_last, e_done, e_if_ack, e_dm_ack, fetch_turn;
        if (!rst) begin
            m_owner = 0; m_cycle = 0; m_passed = 0; m_err = 1'b0;
            check("rst_mem_req", bus.mem_req, 1'b0);
            check("rst_if_ack", bus.if_ack, 1'b0);
            check("rst_dm_ack", bus.dm_ack, 1'b0);
            check("rst_err", err_timeout, 1'b0);
            check("rst_stall_if", stall_if, bus.if_req);
            check("rst_stall_mem", stall_mem, bus.dm_req);
        end else begin
            e_last   = (m_owner != 0) && !bus.mem_ready && (m_cycle == TIMEOUT);
            e_done   = (m_owner != 0) && (bus.mem_ready || e_last);
            e_if_ack = e_done && (m_owner == 1);
            e_dm_ack = e_done && (m_owner == 2);
            check("mem_req", bus.mem_req, (m_owner != 0));
            if (m_owner != 0) begin
                check("mem_addr", bus.mem_addr, m_addr);
                check("mem_we", bus.mem_we, m_we);
                check("mem_be", bus.mem_be, m_be);
                if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
            end
            check("if_ack", bus.if_ack, e_if_ack);
            check("dm_ack", bus.dm_ack, e_dm_ack);
            if (e_if_ack) check("if_rdata", bus.if_rdata, e_last ? 32'd0 : bus.mem_rdata);
            if (e_dm_ack) check("dm_rdata", bus.dm_rdata, e_last ? 32'd0 : bus.mem_rdata);
            check("stall_if", stall_if, bus.if_req && !e_if_ack);
            check("stall_mem", stall_mem, bus.dm_req && !e_dm_ack);
            check("err_timeout", err_timeout, m_err);
            // what the coming rising edge does
            if (m_owner != 0) begin
                if (e_done) begin
                    if (e_last) m_err = 1'b1;
                    m_owner = 0;
                end else begin
                    m_cycle++;
                end
            end else begin
                fetch_turn = bus.if_req && (!bus.dm_req || m_passed >= MAX_WAIT);
                if (bus.dm_req && !fetch_turn) begin
                    m_owner = 2; m_cycle = 1;
                    m_addr = bus.dm_addr; m_we = bus.dm_we;
                    m_wdata = bus.dm_wdata; m_be = bus.dm_be;
                    m_passed = bus.if_req ? ((m_passed < MAX_WAIT) ? m_passed + 1 : MAX_WAIT) : 0;
                    grant_log.push_back(2);
                end else if (bus.if_req) begin
                    m_owner = 1; m_cycle = 1;
                    m_addr = bus.if_addr; m_we = 1'b0; m_be = 4'hF;
                    m_passed = 0;
                    grant_log.push_back(1);
                end else begin
                    m_passed = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        int  base;
        int  busy_n;
        bit  seen_if, seen_dm, t4_end, got;
        logic [31:0] rd;
        int  exp4 [6];
        exp4 = '{2, 2, 2, 2, 1, 2};

        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0;
        bus.dm_wdata = 32'h0; bus.dm_be = 4'h0;
        bus.mem_rdata = 32'h0; bus.mem_ready = 1'b1;

        // 1: reset with requests active
        tick(); #1;
        check("t1_mem_req", bus.mem_req, 1'b0);
        check("t1_if_ack", bus.if_ack, 1'b0);
        check("t1_dm_ack", bus.dm_ack, 1'b0);
        check("t1_stall_if", stall_if, 1'b1);
        check("t1_stall_mem", stall_mem, 1'b1);
        check("t1_err", err_timeout, 1'b0);
        check("t1_mem_addr", bus.mem_addr, 32'h0);
        check("t1_mem_be", bus.mem_be, 4'h0);
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        rst = 1'b1;

        // 2: fetch, ready after two BUSY cycles
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick(); #1;
        check("t2_mem_req", bus.mem_req, 1'b1);
        check("t2_mem_addr", bus.mem_addr, 32'h10);
        check("t2_mem_we", bus.mem_we, 1'b0);
        check("t2_mem_be", bus.mem_be, 4'hF);
        check("t2_if_ack_early", bus.if_ack, 1'b0);
        tick();
        tick(); bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF; #1;
        check("t2_if_ack", bus.if_ack, 1'b1);
        check("t2_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        tick(); bus.if_req = 1'b0; bus.mem_ready = 1'b0; #1;
        check("t2_if_ack_1cyc", bus.if_ack, 1'b0);
        check("t2_mem_req_off", bus.mem_req, 1'b0);
        check("t2_stall_if", stall_if, 1'b0);

        // 3: store and fetch requested together -> data first
        tick();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h200;
        bus.dm_wdata = 32'hA5A5A5A5; bus.dm_be = 4'h3;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        tick(); #1;
        check("t3_mem_we", bus.mem_we, 1'b1);
        check("t3_mem_be", bus.mem_be, 4'h3);
        check("t3_mem_addr", bus.mem_addr, 32'h200);
        check("t3_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        bus.mem_ready = 1'b1; #1;
        check("t3_dm_ack", bus.dm_ack, 1'b1);
        check("t3_if_ack", bus.if_ack, 1'b0);
        tick(); bus.dm_req = 1'b0; bus.mem_ready = 1'b0; #1;
        check("t3_idle_gap", bus.mem_req, 1'b0);
        tick(); #1;
        check("t3_if_addr", bus.mem_addr, 32'h44);
        check("t3_if_we", bus.mem_we, 1'b0);
        bus.mem_ready = 1'b1; #1;
        check("t3_if_ack2", bus.if_ack, 1'b1);
        tick(); bus.if_req = 1'b0; bus.mem_ready = 1'b0;
        check("t3_order_dm", grant_log[grant_log.size()-2], 2);
        check("t3_order_if", grant_log[grant_log.size()-1], 1);

        // 4: starvation guard
        tick();
        base = grant_log.size();
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
        seen_if = 1'b0; seen_dm = 1'b0; t4_end = 1'b0;
        for (int c = 0; c < 60 && !t4_end; c++) begin
            tick();
            if (seen_dm) begin
                if (grant_log.size() - base >= 6) begin
                    bus.dm_req = 1'b0; t4_end = 1'b1;
                end else begin
                    bus.dm_addr = bus.dm_addr + 32'd4;
                end
            end
            if (seen_if) bus.if_req = 1'b0;
            bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
            #1;
            seen_dm = bus.dm_ack; seen_if = bus.if_ack;
        end
        bus.mem_ready = 1'b0;
        check("t4_done", t4_end, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (base + i < grant_log.size()) check("t4_grant_order", grant_log[base+i], exp4[i]);
            else check("t4_grant_missing", 1'b0, 1'b1);
        end

        // 5a: ready in the last allowed cycle -> normal completion
        tick(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2F0;
        for (int c = 0; c < TIMEOUT; c++) begin
            tick();
            bus.mem_ready = (c == TIMEOUT - 1); bus.mem_rdata = 32'h0BADF00D;
        end
        #1;
        check("t5a_dm_ack", bus.dm_ack, 1'b1);
        check("t5a_dm_rdata", bus.dm_rdata, 32'h0BADF00D);
        tick(); bus.dm_req = 1'b0; bus.mem_ready = 1'b0; #1;
        check("t5a_no_err", err_timeout, 1'b0);

        // 5: stuck memory on a load
        tick(); bus.dm_req = 1'b1; bus.dm_addr = 32'h300;
        busy_n = 0; got = 1'b0; rd = 32'hFFFFFFFF;
        for (int c = 0; c < 40 && !got; c++) begin
            tick(); bus.mem_ready = 1'b0; bus.mem_rdata = 32'h12345678; #1;
            if (bus.mem_req) busy_n++;
            if (bus.dm_ack) begin
                got = 1'b1; rd = bus.dm_rdata;
                check("t5_err_not_yet", err_timeout, 1'b0);
            end
        end
        check("t5_acked", got, 1'b1);
        check("t5_busy_cycles", busy_n, TIMEOUT);
        check("t5_rdata_zero", rd, 32'h0);
        tick(); bus.dm_req = 1'b0; #1;
        check("t5_err_set", err_timeout, 1'b1);
        check("t5_mem_req_off", bus.mem_req, 1'b0);
        tick(); bus.dm_req = 1'b1; bus.dm_addr = 32'h304;
        tick(); bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D; #1;
        check("t5_next_ack", bus.dm_ack, 1'b1);
        check("t5_next_rdata", bus.dm_rdata, 32'hCAFEF00D);
        tick(); bus.dm_req = 1'b0; bus.mem_ready = 1'b0; #1;
        check("t5_err_held", err_timeout, 1'b1);

        // 6: reset in the middle of a fetch
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h60;
        tick(); tick();
        bus.mem_ready = 1'b1; #1;
        rst = 1'b0; #1;
        check("t6_mem_req_async", bus.mem_req, 1'b0);
        check("t6_no_ack", bus.if_ack, 1'b0);
        check("t6_err_cleared", err_timeout, 1'b0);
        bus.mem_ready = 1'b0;
        tick(); rst = 1'b1;
        tick(); #1;
        check("t6_regrant", bus.mem_req, 1'b1);
        check("t6_regrant_addr", bus.mem_addr, 32'h60);
        bus.mem_ready = 1'b1; #1;
        check("t6_if_ack", bus.if_ack, 1'b1);
        tick(); bus.if_req = 1'b0; bus.mem_ready = 1'b0;

        // randomized traffic
        seen_if = 1'b0; seen_dm = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (seen_if) begin
                bus.if_req = ($urandom_range(0, 1) == 1); bus.if_addr = $urandom;
            end else if (!bus.if_req && $urandom_range(0, 99) < 40) begin
                bus.if_req = 1'b1; bus.if_addr = $urandom;
            end
            if (seen_dm || (!bus.dm_req && $urandom_range(0, 99) < 40)) begin
                bus.dm_req = seen_dm ? ($urandom_range(0, 1) == 1) : 1'b1;
                bus.dm_we = ($urandom_range(0, 1) == 1);
                bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
                bus.dm_be = 4'($urandom_range(0, 15));
            end
            bus.mem_ready = ((cyc % 500) >= 470) ? 1'b0 : ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
            #1;
            seen_if = bus.if_ack; seen_dm = bus.dm_ack;
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
